// File: rtl/reaction_timer_if.sv
// Signal bundle between the starting-lights sequencer/display path and the reaction timer.
// The timer is the slave; the sequencer, key and display side is the master.
interface reaction_timer_if #(
    parameter int N_BIT = 16
) ();
    logic             tick_ms;
    logic             start;
    logic             lights_out;
    logic             key_n;
    logic [N_BIT-1:0] react_ms;
    logic [N_BIT-1:0] best_ms;
    logic             best_valid;
    logic             result_valid;
    logic             jump_start;
    logic             too_slow;
    logic             busy;

    modport master (
        output tick_ms, start, lights_out, key_n,
        input  react_ms, best_ms, best_valid, result_valid, jump_start, too_slow, busy
    );

    modport slave (
        input  tick_ms, start, lights_out, key_n,
        output react_ms, best_ms, best_valid, result_valid, jump_start, too_slow, busy
    );
endinterface

// File: rtl/reaction_timer.sv
// Responder side of the starting-lights game: detects false starts and measures
// reaction time in ms, keeping the best valid time since reset.
//
// state  | meaning
// IDLE   | no attempt since reset
// ARMED  | lights sequence running, a press now is a jump start
// TIMING | lights out, counting ms until the key press
// DONE   | measured (or timed-out) result held
// FAULT  | jump start recorded and held
module reaction_timer #(
    parameter int N_BIT  = 16,
    parameter int MAX_MS = 9999
) (
    input  logic          clk,
    input  logic          rst_n,
    reaction_timer_if.slave bus
);
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_TIMING,
        ST_DONE,
        ST_FAULT
    } state_t;

    localparam logic [N_BIT-1:0] ONE      = N_BIT'(1);
    localparam logic [N_BIT-1:0] MAX_VAL  = N_BIT'(MAX_MS);
    localparam logic [N_BIT-1:0] MAX_LAST = N_BIT'(MAX_MS - 1);

    state_t           state_q, state_d;
    logic [N_BIT-1:0] counter_q, counter_d;
    logic [N_BIT-1:0] react_q, react_d;
    logic [N_BIT-1:0] best_q, best_d;
    logic             best_valid_q, best_valid_d;
    logic             result_valid_q, result_valid_d;
    logic             jump_q, jump_d;
    logic             slow_q, slow_d;
    logic             busy_q;
    logic             key_s1, key_s2, key_s3;
    logic             press;

    // Key is asynchronous: two flops to resolve metastability, a third to find the falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_s1 <= 1'b1;
            key_s2 <= 1'b1;
            key_s3 <= 1'b1;
        end else begin
            key_s1 <= bus.key_n;
            key_s2 <= key_s1;
            key_s3 <= key_s2;
        end
    end

    assign press = key_s3 & ~key_s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            counter_q      <= '0;
            react_q        <= '0;
            best_q         <= '1;
            best_valid_q   <= 1'b0;
            result_valid_q <= 1'b0;
            jump_q         <= 1'b0;
            slow_q         <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            counter_q      <= counter_d;
            react_q        <= react_d;
            best_q         <= best_d;
            best_valid_q   <= best_valid_d;
            result_valid_q <= result_valid_d;
            jump_q         <= jump_d;
            slow_q         <= slow_d;
            busy_q         <= (state_d == ST_ARMED) || (state_d == ST_TIMING);
        end
    end

    always_comb begin
        state_d        = state_q;
        counter_d      = counter_q;
        react_d        = react_q;
        best_d         = best_q;
        best_valid_d   = best_valid_q;
        result_valid_d = 1'b0;
        jump_d         = jump_q;
        slow_d         = slow_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_ARMED;
                    jump_d  = 1'b0;
                    slow_d  = 1'b0;
                end
            end
            ST_ARMED: begin
                // A press in the same cycle as lights_out is still a false start.
                if (press) begin
                    state_d        = ST_FAULT;
                    jump_d         = 1'b1;
                    result_valid_d = 1'b1;
                end else if (bus.lights_out) begin
                    state_d   = ST_TIMING;
                    counter_d = '0;
                end
            end
            ST_TIMING: begin
                if (press) begin
                    state_d        = ST_DONE;
                    react_d        = counter_q;
                    result_valid_d = 1'b1;
                    if (!best_valid_q || (counter_q < best_q)) begin
                        best_d       = counter_q;
                        best_valid_d = 1'b1;
                    end
                end else if (bus.tick_ms) begin
                    if (counter_q == MAX_LAST) begin
                        state_d        = ST_DONE;
                        counter_d      = MAX_VAL;
                        react_d        = MAX_VAL;
                        slow_d         = 1'b1;
                        result_valid_d = 1'b1;
                    end else begin
                        counter_d = counter_q + ONE;
                    end
                end
            end
            ST_DONE, ST_FAULT: begin
                if (bus.start) begin
                    state_d = ST_ARMED;
                    jump_d  = 1'b0;
                    slow_d  = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.react_ms     = react_q;
    assign bus.best_ms      = best_q;
    assign bus.best_valid   = best_valid_q;
    assign bus.result_valid = result_valid_q;
    assign bus.jump_start   = jump_q;
    assign bus.too_slow     = slow_q;
    assign bus.busy         = busy_q;
endmodule

// File: tb/tb_reaction_timer.sv
// Directed bench for reaction_timer: expected results are queued when an attempt is
// issued and a monitor compares them whenever result_valid is seen.
module tb_reaction_timer;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    bit   done;

    typedef struct {
        logic [15:0] react;
        logic [15:0] best;
        logic        bv;
        logic        jump;
        logic        slow;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] react_m;
    logic [15:0] best_m;
    logic        bv_m;

    reaction_timer_if #(.N_BIT(16)) bus ();

    reaction_timer #(.N_BIT(16), .MAX_MS(9999)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic expect_result(input logic [15:0] r, input logic jump, input logic slow);
        exp_t e;
        if (!jump) begin
            react_m = r;
            if (!slow && (!bv_m || r < best_m)) begin
                best_m = r;
                bv_m   = 1'b1;
            end
        end
        e.react = react_m;
        e.best  = best_m;
        e.bv    = bv_m;
        e.jump  = jump;
        e.slow  = slow;
        sb.push_back(e);
    endtask

    task automatic monitor_loop();
        exp_t e;
        while (!done) begin
            @(negedge clk);
            if (bus.result_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_result_valid actual=1 required=0");
                end else begin
                    e = sb.pop_front();
                    check("mon_react_ms", 32'(bus.react_ms), 32'(e.react));
                    check("mon_best_ms", 32'(bus.best_ms), 32'(e.best));
                    check("mon_best_valid", 32'(bus.best_valid), 32'(e.bv));
                    check("mon_jump_start", 32'(bus.jump_start), 32'(e.jump));
                    check("mon_too_slow", 32'(bus.too_slow), 32'(e.slow));
                end
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic pulse_lights_out();
        bus.lights_out = 1'b1;
        @(negedge clk);
        bus.lights_out = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            bus.tick_ms = 1'b1;
            @(negedge clk);
            bus.tick_ms = 1'b0;
        end
    endtask

    // key low sampled at edge k, press seen in the cycle after k+1, result at edge k+2
    task automatic press_key(input string tag);
        bus.key_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check({tag, "_rv_early"}, 32'(bus.result_valid), 32'd0);
        @(negedge clk);
        check({tag, "_rv_latency"}, 32'(bus.result_valid), 32'd1);
        @(negedge clk);
        check({tag, "_rv_one_cycle"}, 32'(bus.result_valid), 32'd0);
        bus.key_n = 1'b1;
        idle(3);
    endtask

    task automatic attempt(input int ms, input string tag);
        expect_result(16'(ms), 1'b0, 1'b0);
        pulse_start();
        check({tag, "_busy_armed"}, 32'(bus.busy), 32'd1);
        idle(5);
        pulse_lights_out();
        ticks(ms);
        press_key(tag);
        check({tag, "_busy_done"}, 32'(bus.busy), 32'd0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_react_ms"}, 32'(bus.react_ms), 32'd0);
        check({tag, "_best_ms"}, 32'(bus.best_ms), 32'hFFFF);
        check({tag, "_best_valid"}, 32'(bus.best_valid), 32'd0);
        check({tag, "_result_valid"}, 32'(bus.result_valid), 32'd0);
        check({tag, "_jump_start"}, 32'(bus.jump_start), 32'd0);
        check({tag, "_too_slow"}, 32'(bus.too_slow), 32'd0);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    endtask

    task automatic stimulus();
        rst_n          = 1'b0;
        bus.tick_ms    = 1'b0;
        bus.start      = 1'b0;
        bus.lights_out = 1'b0;
        bus.key_n      = 1'b1;
        react_m        = 16'd0;
        best_m         = 16'hFFFF;
        bv_m           = 1'b0;
        idle(3);
        check_reset_values("reset");
        rst_n = 1'b1;
        idle(2);
        check_reset_values("post_reset");

        attempt(237, "a237");
        attempt(412, "a412");
        attempt(150, "a150");

        // false start, then a late lights_out and key press must be ignored
        expect_result(16'd0, 1'b1, 1'b0);
        pulse_start();
        idle(2);
        press_key("jump");
        check("jump_level", 32'(bus.jump_start), 32'd1);
        check("jump_busy", 32'(bus.busy), 32'd0);
        pulse_lights_out();
        ticks(20);
        press_key_ignored();
        check("fault_hold_react", 32'(bus.react_ms), 32'd150);
        check("fault_hold_jump", 32'(bus.jump_start), 32'd1);

        // key held low across the whole attempt: no press, so it times out
        bus.key_n = 1'b0;
        idle(5);
        expect_result(16'd9999, 1'b0, 1'b1);
        pulse_start();
        check("start_clears_jump", 32'(bus.jump_start), 32'd0);
        idle(5);
        pulse_lights_out();
        ticks(9998);
        check("before_timeout_busy", 32'(bus.busy), 32'd1);
        ticks(1);
        check("timeout_too_slow", 32'(bus.too_slow), 32'd1);
        check("timeout_busy", 32'(bus.busy), 32'd0);
        idle(3);
        bus.key_n = 1'b1;
        idle(5);

        // press and tick on the same edge at count 88
        expect_result(16'd88, 1'b0, 1'b0);
        pulse_start();
        check("start_clears_slow", 32'(bus.too_slow), 32'd0);
        idle(3);
        pulse_lights_out();
        ticks(88);
        bus.key_n = 1'b0;
        idle(2);
        bus.tick_ms = 1'b1;
        @(negedge clk);
        bus.tick_ms = 1'b0;
        check("tick_press_rv", 32'(bus.result_valid), 32'd1);
        idle(3);
        bus.key_n = 1'b1;
        idle(3);

        // press and lights_out on the same edge is a false start
        expect_result(16'd0, 1'b1, 1'b0);
        pulse_start();
        idle(3);
        bus.key_n = 1'b0;
        idle(2);
        bus.lights_out = 1'b1;
        @(negedge clk);
        bus.lights_out = 1'b0;
        check("lo_press_jump", 32'(bus.jump_start), 32'd1);
        check("lo_press_busy", 32'(bus.busy), 32'd0);
        idle(3);
        bus.key_n = 1'b1;
        idle(3);

        // asynchronous reset in the middle of timing at count 40
        pulse_start();
        idle(2);
        pulse_lights_out();
        ticks(40);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_values("mid_reset");
        react_m = 16'd0;
        best_m  = 16'hFFFF;
        bv_m    = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        attempt(5, "after_reset");
        check("final_best", 32'(bus.best_ms), 32'd5);

        idle(3);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        done = 1'b1;
    endtask

    task automatic press_key_ignored();
        bus.key_n = 1'b0;
        idle(4);
        bus.key_n = 1'b1;
        idle(3);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        done     = 1'b0;
        fork
            monitor_loop();
            stimulus();
        join
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end
endmodule
